// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive controller.
//   state_e    : receiver FSM states (IDLE, DATA, STOP)
//   DATA_W_DEF : default number of data bits per frame
package serial_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_e;

endpackage

// File: rtl/serial_rx_ctrl_if.sv
// Output handshake between the serial receiver and its consumer.
//   data_out   : last completed frame (producer -> consumer)
//   data_valid : data_out holds an unaccepted frame (producer -> consumer)
//   out_ready  : consumer accepts data_out this cycle (consumer -> producer)
interface serial_rx_ctrl_if
  import serial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              out_ready;

  modport master (output data_out, output data_valid, input out_ready);
  modport slave  (input data_out, input data_valid, output out_ready);

endinterface

// File: rtl/serial_shift_reg.sv
// Right-shifting deserializer: serial data enters at the MSB, so after
// DATA_W enabled shifts the first received bit sits in bit 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (wins over en_i)
//   en_i       : shift one position
//   ser_i      : serial input bit
//   par_o      : parallel contents
module serial_shift_reg
  import serial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              ser_i,
  output logic [DATA_W-1:0] par_o
);

  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;

  // Next contents: clear, shift, or hold.
  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (en_i) begin
      sr_d = {ser_i, sr_q[DATA_W-1:1]};
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign par_o = sr_q;

endmodule

// File: rtl/serial_rx_ctrl.sv
// Serial frame receiver: start bit (0), DATA_W data bits LSB first, stop
// bit (1). serial_in is only looked at on bit_tick cycles. Completed
// frames go to a one-entry holding register with a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   serial_in  : serial line, idle high
//   bit_tick   : one-cycle sample strobe
//   clr_err    : clears the sticky overrun flag
//   rx         : data_out / data_valid / out_ready handshake (master side)
//   busy       : FSM not in IDLE
//   frame_err  : one-cycle pulse after a bad stop bit
//   overrun    : sticky, a completed frame was dropped
// CNT_W must satisfy 2**CNT_W > DATA_W.
module serial_rx_ctrl
  import serial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              bit_tick,
  input  logic              clr_err,
  serial_rx_ctrl_if.master  rx,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] sr_par;
  logic              valid_q, valid_d;
  logic              busy_q;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              ovr_evt;
  logic              sr_clr, sr_en, load;

  serial_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (sr_clr),
    .en_i  (sr_en),
    .ser_i (serial_in),
    .par_o (sr_par)
  );

  // FSM next state, bit counter and shift/load/error strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_clr  = 1'b0;
    sr_en   = 1'b0;
    load    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bit_tick && !serial_in) begin
          state_d = DATA;
          cnt_d   = '0;
          sr_clr  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (bit_tick) begin
          sr_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
          if (serial_in) begin
            load = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Holding register and handshake. A load over a pending frame is only
  // an overrun when the consumer is not taking the old frame this cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_evt = 1'b0;
    if (load) begin
      if (valid_q && !rx.out_ready) begin
        ovr_evt = 1'b1;
      end else begin
        data_d  = sr_par;
        valid_d = 1'b1;
      end
    end else if (valid_q && rx.out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    // A new overrun event beats a simultaneous clear.
    ovr_d = ovr_evt | (ovr_q & ~clr_err);
  end

  // State, counter, holding register and flag storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != IDLE);
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx.data_out   = data_q;
  assign rx.data_valid = valid_q;
  assign busy          = busy_q;
  assign frame_err     = ferr_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Self-checking bench for serial_rx_ctrl. Frames accepted by the consumer
// are compared against a queue of expected frames; everything else goes
// through check_eq directly.
module tb_serial_rx_ctrl;

  logic clk;
  logic rst_n;
  logic serial_in;
  logic bit_tick;
  logic clr_err;
  logic busy;
  logic frame_err;
  logic overrun;

  int n_checks;
  int n_errors;
  logic [7:0] exp_q[$];

  serial_rx_ctrl_if #(.DATA_W(8)) rx_if ();

  serial_rx_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .serial_in (serial_in),
    .bit_tick  (bit_tick),
    .clr_err   (clr_err),
    .rx        (rx_if.master),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer side: every accepted frame must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && rx_if.data_valid && rx_if.out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_accept", 32'(rx_if.data_out), 32'hFFFF_FFFF);
      end else begin
        check_eq("accepted_frame", 32'(rx_if.data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  // Two idle cycles, then one bit_tick cycle; returns 1 time unit after the
  // tick's sampling edge. out_ready is driven only during the tick cycle.
  task automatic tick(input logic b, input logic rdy);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    serial_in       = b;
    bit_tick        = 1'b1;
    rx_if.out_ready = rdy;
    @(posedge clk);
    #1;
    bit_tick        = 1'b0;
    rx_if.out_ready = 1'b0;
    serial_in       = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic rdy_stop);
    tick(1'b0, 1'b0);
    check_eq("busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick(d[i], 1'b0);
      check_eq("busy_data", 32'(busy), 32'd1);
    end
    tick(stop_b, rdy_stop);
    check_eq("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic accept();
    @(posedge clk);
    #1;
    rx_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_if.out_ready = 1'b0;
    check_eq("valid_cleared", 32'(rx_if.data_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_data"},  32'(rx_if.data_out), 32'd0);
    check_eq({tag, "_valid"}, 32'(rx_if.data_valid), 32'd0);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
    check_eq({tag, "_ferr"},  32'(frame_err), 32'd0);
    check_eq({tag, "_ovr"},   32'(overrun), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    serial_in       = 1'b1;
    bit_tick        = 1'b0;
    clr_err         = 1'b0;
    rx_if.out_ready = 1'b0;
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle line: ticks with serial_in=1 must not start a frame.
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0);
      check_eq("idle_busy", 32'(busy), 32'd0);
    end
    check_all_zero("idle");

    // Good frame 0xC1.
    exp_q.push_back(8'hC1);
    send_frame(8'hC1, 1'b1, 1'b0);
    check_eq("c1_valid", 32'(rx_if.data_valid), 32'd1);
    check_eq("c1_data",  32'(rx_if.data_out), 32'h0C1);
    check_eq("c1_ferr",  32'(frame_err), 32'd0);
    accept();

    // Bad stop bit: one-cycle frame_err, nothing loaded.
    send_frame(8'hC1, 1'b0, 1'b0);
    check_eq("ferr_pulse", 32'(frame_err), 32'd1);
    check_eq("ferr_valid", 32'(rx_if.data_valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("ferr_end", 32'(frame_err), 32'd0);
    check_eq("ferr_busy", 32'(busy), 32'd0);

    // Overrun: 0xA5 pending, 0x3C lost.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    check_eq("ovr_data",  32'(rx_if.data_out), 32'h0A5);
    check_eq("ovr_valid", 32'(rx_if.data_valid), 32'd1);
    check_eq("ovr_set",   32'(overrun), 32'd1);
    accept();
    check_eq("ovr_sticky", 32'(overrun), 32'd1);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    check_eq("ovr_clear", 32'(overrun), 32'd0);

    // Load in the same cycle the pending frame is accepted.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1);
    check_eq("swap_data",  32'(rx_if.data_out), 32'h03C);
    check_eq("swap_valid", 32'(rx_if.data_valid), 32'd1);
    check_eq("swap_ovr",   32'(overrun), 32'd0);
    accept();

    // Reset in the middle of a frame.
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    check_eq("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("after_rst");
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    check_eq("f55_valid", 32'(rx_if.data_valid), 32'd1);
    check_eq("f55_data",  32'(rx_if.data_out), 32'h055);
    accept();

    @(posedge clk);
    #1;
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
